// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle sequencing controller: FSM states,
// sticky fault codes and memory access size codes.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_MDU   = 3'd4,
        S_WB    = 3'd5,
        S_TRAP  = 3'd6,
        S_HALT  = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_ILLEGAL  = 2'd1,
        ERR_MISALIGN = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } err_t;

    localparam logic [1:0] MSZ_B = 2'd0;
    localparam logic [1:0] MSZ_H = 2'd1;
    localparam logic [1:0] MSZ_W = 2'd2;
    localparam logic [1:0] MSZ_D = 2'd3;

endpackage

// File: rtl/wmask_gen.sv
// Byte-lane write mask and alignment checks for a load/store access.
// Purely combinational: mask = ((1 << (1 << size)) - 1) << addr_lo, truncated to BW lanes.
module wmask_gen
    import ctrl_pkg::*;
#(
    parameter int  XLEN = 64,
    localparam int BW   = XLEN / 8,
    localparam int AW   = $clog2(BW)
) (
    input  logic [1:0]    mem_size,
    input  logic [AW-1:0] mem_addr_lo,
    output logic [BW-1:0] wmask,
    output logic          misaligned,
    output logic          size_illegal
);

    logic [AW-1:0] align_mask;
    int            nbytes;

    // Access width in bytes and the low address bits that must be zero for it
    always_comb begin
        align_mask = '0;
        nbytes     = 1;
        case (mem_size)
            MSZ_B:   begin align_mask = '0;     nbytes = 1; end
            MSZ_H:   begin align_mask = AW'(1); nbytes = 2; end
            MSZ_W:   begin align_mask = AW'(3); nbytes = 4; end
            default: begin align_mask = AW'(7); nbytes = 8; end
        endcase
    end

    // Lanes covered by the access; lanes past the top of the word simply drop off
    always_comb begin
        wmask = '0;
        for (int i = 0; i < BW; i++) begin
            wmask[i] = (i >= int'(mem_addr_lo)) && (i < int'(mem_addr_lo) + nbytes);
        end
    end

    assign misaligned   = |(mem_addr_lo & align_mask);
    assign size_illegal = (XLEN == 32) && (mem_size == MSZ_D);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencing controller: fetch, execute, memory / mul-div wait,
// writeback and trap, with a sticky HALT on illegal, misaligned or timed-out
// instructions. All outputs except lsu_wmask are registers.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int  XLEN    = 64,
    parameter int  TIMEOUT = 255,
    localparam int BW      = XLEN / 8,
    localparam int AW      = $clog2(BW)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          ifu_req,
    input  logic          ifu_valid,
    input  logic          dec_load,
    input  logic          dec_store,
    input  logic          dec_mdu,
    input  logic          dec_csr,
    input  logic          dec_trap,
    input  logic          dec_illegal,
    input  logic          dec_rd_wen,
    input  logic [1:0]    mem_size,
    input  logic [AW-1:0] mem_addr_lo,
    output logic          lsu_req,
    output logic          lsu_wen,
    output logic [BW-1:0] lsu_wmask,
    input  logic          lsu_resp,
    output logic          mdu_start,
    input  logic          mdu_done,
    output logic          inst_update,
    output logic          rf_wen,
    output logic          pc_wen,
    output logic          csr_wen,
    output logic          trap,
    output logic          halted,
    output logic [1:0]    err_code,
    output logic [2:0]    state
);

    localparam int            CW    = $clog2(TIMEOUT + 1);
    // Counter value during the last permitted wait cycle (it reads 0 in the first one)
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    state_t        st, st_n;
    err_t          err_q, err_n;
    logic [CW-1:0] cnt;
    logic          at_limit;
    logic [BW-1:0] base_mask;
    logic          misaligned;
    logic          size_illegal;

    wmask_gen #(.XLEN(XLEN)) u_wmask (
        .mem_size     (mem_size),
        .mem_addr_lo  (mem_addr_lo),
        .wmask        (base_mask),
        .misaligned   (misaligned),
        .size_illegal (size_illegal)
    );

    assign at_limit  = (cnt == LIMIT);
    assign lsu_wmask = (st == S_MEM && lsu_wen) ? base_mask : '0;
    assign state     = st;
    assign err_code  = err_q;

    // Next state and fault code; a response in the limit cycle beats the timeout
    always_comb begin
        st_n  = st;
        err_n = err_q;
        case (st)
            S_IDLE: st_n = S_FETCH;
            S_FETCH: begin
                if (ifu_valid) begin
                    st_n = S_EXEC;
                end else if (at_limit) begin
                    st_n  = S_HALT;
                    err_n = ERR_TIMEOUT;
                end
            end
            S_EXEC: begin
                if (dec_illegal) begin
                    st_n  = S_HALT;
                    err_n = ERR_ILLEGAL;
                end else if (dec_trap) begin
                    st_n = S_TRAP;
                end else if (dec_load || dec_store) begin
                    if (misaligned || size_illegal) begin
                        st_n  = S_HALT;
                        err_n = ERR_MISALIGN;
                    end else begin
                        st_n = S_MEM;
                    end
                end else if (dec_mdu) begin
                    st_n = S_MDU;
                end else begin
                    st_n = S_WB;
                end
            end
            S_MEM: begin
                if (lsu_resp) begin
                    st_n = S_WB;
                end else if (at_limit) begin
                    st_n  = S_HALT;
                    err_n = ERR_TIMEOUT;
                end
            end
            S_MDU: begin
                // mdu_start is high only in the launch cycle, where mdu_done is not trusted
                if (!mdu_start && mdu_done) begin
                    st_n = S_WB;
                end else if (at_limit) begin
                    st_n  = S_HALT;
                    err_n = ERR_TIMEOUT;
                end
            end
            S_WB:    st_n = S_FETCH;
            S_TRAP:  st_n = S_FETCH;
            S_HALT:  st_n = S_HALT;
            default: st_n = S_IDLE;
        endcase
    end

    // State, wait counter and outputs registered from the upcoming state
    always_ff @(posedge clk) begin
        if (rst) begin
            st          <= S_IDLE;
            err_q       <= ERR_NONE;
            cnt         <= '0;
            ifu_req     <= 1'b0;
            lsu_req     <= 1'b0;
            lsu_wen     <= 1'b0;
            mdu_start   <= 1'b0;
            inst_update <= 1'b0;
            rf_wen      <= 1'b0;
            pc_wen      <= 1'b0;
            csr_wen     <= 1'b0;
            trap        <= 1'b0;
            halted      <= 1'b0;
        end else begin
            st    <= st_n;
            err_q <= err_n;
            if (st_n != st) begin
                cnt <= '0;
            end else if (!at_limit) begin
                cnt <= cnt + 1'b1;
            end
            ifu_req     <= (st_n == S_FETCH);
            lsu_req     <= (st_n == S_MEM);
            lsu_wen     <= (st_n == S_MEM) && dec_store;
            mdu_start   <= (st_n == S_MDU) && (st == S_EXEC);
            inst_update <= (st_n == S_WB) || (st_n == S_TRAP);
            pc_wen      <= (st_n == S_WB) || (st_n == S_TRAP);
            rf_wen      <= (st_n == S_WB) && dec_rd_wen && !dec_store;
            csr_wen     <= (st_n == S_WB) && dec_csr;
            trap        <= (st_n == S_TRAP);
            halted      <= (st_n == S_HALT);
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl. Three instances share the input stimulus:
// [0] XLEN=64 TIMEOUT=255, [1] XLEN=64 TIMEOUT=8, [2] XLEN=32 TIMEOUT=255.
// Each has its own reset so only the instance under test is running.
module tb_multicycle_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, rst1, rst2;
    logic       ifu_valid, dec_load, dec_store, dec_mdu, dec_csr, dec_trap, dec_illegal, dec_rd_wen;
    logic [1:0] mem_size;
    logic [2:0] addr_lo;
    logic       lsu_resp, mdu_done;

    logic       ifu_req[3], lsu_req[3], lsu_wen[3], mdu_start[3], inst_update[3];
    logic       rf_wen[3], pc_wen[3], csr_wen[3], trap[3], halted[3];
    logic [1:0] err[3];
    logic [2:0] st[3];
    logic [7:0] wm0, wm1;
    logic [3:0] wm2;

    int n_tests = 0;
    int n_fail  = 0;

    multicycle_ctrl #(.XLEN(64), .TIMEOUT(255)) dut0 (
        .clk(clk), .rst(rst0), .ifu_req(ifu_req[0]), .ifu_valid(ifu_valid),
        .dec_load(dec_load), .dec_store(dec_store), .dec_mdu(dec_mdu), .dec_csr(dec_csr),
        .dec_trap(dec_trap), .dec_illegal(dec_illegal), .dec_rd_wen(dec_rd_wen),
        .mem_size(mem_size), .mem_addr_lo(addr_lo), .lsu_req(lsu_req[0]), .lsu_wen(lsu_wen[0]),
        .lsu_wmask(wm0), .lsu_resp(lsu_resp), .mdu_start(mdu_start[0]), .mdu_done(mdu_done),
        .inst_update(inst_update[0]), .rf_wen(rf_wen[0]), .pc_wen(pc_wen[0]), .csr_wen(csr_wen[0]),
        .trap(trap[0]), .halted(halted[0]), .err_code(err[0]), .state(st[0])
    );

    multicycle_ctrl #(.XLEN(64), .TIMEOUT(8)) dut1 (
        .clk(clk), .rst(rst1), .ifu_req(ifu_req[1]), .ifu_valid(ifu_valid),
        .dec_load(dec_load), .dec_store(dec_store), .dec_mdu(dec_mdu), .dec_csr(dec_csr),
        .dec_trap(dec_trap), .dec_illegal(dec_illegal), .dec_rd_wen(dec_rd_wen),
        .mem_size(mem_size), .mem_addr_lo(addr_lo), .lsu_req(lsu_req[1]), .lsu_wen(lsu_wen[1]),
        .lsu_wmask(wm1), .lsu_resp(lsu_resp), .mdu_start(mdu_start[1]), .mdu_done(mdu_done),
        .inst_update(inst_update[1]), .rf_wen(rf_wen[1]), .pc_wen(pc_wen[1]), .csr_wen(csr_wen[1]),
        .trap(trap[1]), .halted(halted[1]), .err_code(err[1]), .state(st[1])
    );

    multicycle_ctrl #(.XLEN(32), .TIMEOUT(255)) dut2 (
        .clk(clk), .rst(rst2), .ifu_req(ifu_req[2]), .ifu_valid(ifu_valid),
        .dec_load(dec_load), .dec_store(dec_store), .dec_mdu(dec_mdu), .dec_csr(dec_csr),
        .dec_trap(dec_trap), .dec_illegal(dec_illegal), .dec_rd_wen(dec_rd_wen),
        .mem_size(mem_size), .mem_addr_lo(addr_lo[1:0]), .lsu_req(lsu_req[2]), .lsu_wen(lsu_wen[2]),
        .lsu_wmask(wm2), .lsu_resp(lsu_resp), .mdu_start(mdu_start[2]), .mdu_done(mdu_done),
        .inst_update(inst_update[2]), .rf_wen(rf_wen[2]), .pc_wen(pc_wen[2]), .csr_wen(csr_wen[2]),
        .trap(trap[2]), .halted(halted[2]), .err_code(err[2]), .state(st[2])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifu_valid = 0; dec_load = 0; dec_store = 0; dec_mdu = 0; dec_csr = 0;
        dec_trap = 0; dec_illegal = 0; dec_rd_wen = 0; mem_size = 0; addr_lo = 0;
        lsu_resp = 0; mdu_done = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        int starts;
        rst0 = 1; rst1 = 1; rst2 = 1;
        clear_inputs();
        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            chk("rst_state", st[i], 0);
            chk("rst_ifu_req", ifu_req[i], 0);
            chk("rst_halted", halted[i], 0);
            chk("rst_err", err[i], 0);
            chk("rst_commit", inst_update[i], 0);
        end

        // ALU commit: ifu_valid in the third FETCH cycle
        rst0 = 0;
        tick();
        chk("alu_fetch_state", st[0], 1);
        chk("alu_ifu_req", ifu_req[0], 1);
        tick(); tick();
        chk("alu_fetch3_req", ifu_req[0], 1);
        ifu_valid = 1; dec_rd_wen = 1;
        tick();
        ifu_valid = 0;
        chk("alu_exec_state", st[0], 2);
        chk("alu_exec_req", ifu_req[0], 0);
        chk("alu_exec_commit", inst_update[0], 0);
        tick();
        chk("alu_wb_state", st[0], 5);
        chk("alu_wb_commit", inst_update[0], 1);
        chk("alu_wb_rf", rf_wen[0], 1);
        chk("alu_wb_pc", pc_wen[0], 1);
        chk("alu_wb_csr", csr_wen[0], 0);
        tick();
        chk("alu_back_fetch", st[0], 1);
        chk("alu_commit_drop", inst_update[0], 0);

        // sw at addr_lo=4, response in the 5th MEM cycle
        dec_store = 1; mem_size = 2; addr_lo = 4; ifu_valid = 1;
        tick();
        ifu_valid = 0;
        chk("sw_exec_mask", wm0, 8'h00);
        tick();
        chk("sw_wen", lsu_wen[0], 1);
        chk("sw_mask", wm0, 8'hF0);
        cyc = 0;
        for (int k = 1; k <= 5; k++) begin
            if (lsu_req[0] === 1'b1 && st[0] === 3'd3) cyc++;
            if (k == 5) lsu_resp = 1;
            tick();
        end
        lsu_resp = 0;
        chk("sw_req_cycles", cyc, 5);
        chk("sw_wb_state", st[0], 5);
        chk("sw_wb_commit", inst_update[0], 1);
        chk("sw_wb_rf", rf_wen[0], 0);
        chk("sw_wb_req", lsu_req[0], 0);
        chk("sw_wb_mask", wm0, 8'h00);
        tick();

        // sb at addr_lo=7
        mem_size = 0; addr_lo = 7; ifu_valid = 1;
        tick();
        ifu_valid = 0;
        tick();
        chk("sb_mask", wm0, 8'h80);
        lsu_resp = 1;
        tick();
        lsu_resp = 0;
        chk("sb_wb_commit", inst_update[0], 1);
        chk("sb_wb_rf", rf_wen[0], 0);
        tick();

        // ld: no write enable, no mask, rd written
        dec_store = 0; dec_load = 1; mem_size = 3; addr_lo = 0; ifu_valid = 1;
        tick();
        ifu_valid = 0;
        tick();
        chk("ld_req", lsu_req[0], 1);
        chk("ld_wen", lsu_wen[0], 0);
        chk("ld_mask", wm0, 8'h00);
        lsu_resp = 1;
        tick();
        lsu_resp = 0;
        chk("ld_wb_rf", rf_wen[0], 1);
        tick();
        dec_load = 0;

        // csrrw commits with csr_wen
        dec_csr = 1; ifu_valid = 1;
        tick();
        ifu_valid = 0;
        tick();
        chk("csr_wb_csr", csr_wen[0], 1);
        chk("csr_wb_rf", rf_wen[0], 1);
        tick();

        // ecall outranks a misaligned load and suppresses rf/csr writes
        dec_trap = 1; dec_load = 1; mem_size = 1; addr_lo = 1; ifu_valid = 1;
        tick();
        ifu_valid = 0;
        tick();
        chk("trap_state", st[0], 6);
        chk("trap_pulse", trap[0], 1);
        chk("trap_pc", pc_wen[0], 1);
        chk("trap_commit", inst_update[0], 1);
        chk("trap_rf", rf_wen[0], 0);
        chk("trap_csr", csr_wen[0], 0);
        tick();
        chk("trap_back_fetch", st[0], 1);
        chk("trap_drop", trap[0], 0);
        dec_trap = 0; dec_load = 0; dec_csr = 0; mem_size = 0; addr_lo = 0;

        // mul: done in the launch cycle ignored, real done 33 cycles later
        dec_mdu = 1; ifu_valid = 1;
        tick();
        ifu_valid = 0;
        tick();
        chk("mul_state", st[0], 4);
        chk("mul_start", mdu_start[0], 1);
        mdu_done = 1;
        tick();
        mdu_done = 0;
        chk("mul_early_done_ignored", st[0], 4);
        starts = 0; cyc = 0;
        for (int k = 2; k <= 33; k++) begin
            if (mdu_start[0] === 1'b1) starts++;
            if (st[0] === 3'd4) cyc++;
            tick();
        end
        chk("mul_single_start", starts, 0);
        chk("mul_wait_cycles", cyc, 32);
        mdu_done = 1;
        tick();
        mdu_done = 0;
        chk("mul_wb_state", st[0], 5);
        chk("mul_wb_rf", rf_wen[0], 1);
        tick();

        // reset in the middle of an MDU wait
        ifu_valid = 1;
        tick();
        ifu_valid = 0;
        tick(); tick();
        rst0 = 1;
        tick();
        chk("mdu_rst_state", st[0], 0);
        chk("mdu_rst_start", mdu_start[0], 0);
        chk("mdu_rst_req", ifu_req[0], 0);
        rst0 = 0;
        starts = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (mdu_start[0] === 1'b1) starts++;
        end
        chk("mdu_rst_no_restart", starts, 0);
        chk("mdu_rst_fetch", st[0], 1);
        dec_mdu = 0;

        // sh at addr_lo=1: misaligned halt, no memory request
        dec_store = 1; mem_size = 1; addr_lo = 1; ifu_valid = 1;
        tick();
        ifu_valid = 0;
        cyc = (lsu_req[0] === 1'b1) ? 1 : 0;
        tick();
        chk("sh_halt_state", st[0], 7);
        chk("sh_halted", halted[0], 1);
        chk("sh_err", err[0], 2);
        ifu_valid = 1; lsu_resp = 1;
        tick();
        if (lsu_req[0] === 1'b1) cyc++;
        ifu_valid = 0; lsu_resp = 0;
        tick();
        if (lsu_req[0] === 1'b1) cyc++;
        chk("sh_no_req", cyc, 0);
        chk("sh_err_held", err[0], 2);

        // illegal outranks trap and an aligned load
        rst0 = 1;
        tick();
        rst0 = 0;
        clear_inputs();
        tick();
        dec_illegal = 1; dec_trap = 1; dec_load = 1; ifu_valid = 1;
        tick();
        ifu_valid = 0;
        tick();
        chk("ill_state", st[0], 7);
        chk("ill_err", err[0], 1);
        chk("ill_commit", inst_update[0], 0);
        rst0 = 1;
        clear_inputs();

        // TIMEOUT=8: no response -> timeout fault after 8 MEM cycles
        rst1 = 0;
        tick();
        dec_load = 1; mem_size = 3; dec_rd_wen = 1; ifu_valid = 1;
        tick();
        ifu_valid = 0;
        tick();
        cyc = 0;
        for (int k = 1; k <= 8; k++) begin
            if (st[1] === 3'd3) cyc++;
            tick();
        end
        chk("to_mem_cycles", cyc, 8);
        chk("to_state", st[1], 7);
        chk("to_err", err[1], 3);
        chk("to_halted", halted[1], 1);
        lsu_resp = 1; ifu_valid = 1;
        tick(); tick();
        lsu_resp = 0; ifu_valid = 0;
        chk("to_persist_state", st[1], 7);
        chk("to_persist_err", err[1], 3);
        chk("to_persist_req", lsu_req[1], 0);
        rst1 = 1;
        tick();
        chk("to_rst_state", st[1], 0);
        chk("to_rst_halted", halted[1], 0);
        chk("to_rst_err", err[1], 0);

        // TIMEOUT=8: response in exactly the 8th cycle wins
        rst1 = 0;
        tick();
        ifu_valid = 1;
        tick();
        ifu_valid = 0;
        tick();
        for (int k = 1; k <= 8; k++) begin
            if (k == 8) lsu_resp = 1;
            tick();
        end
        lsu_resp = 0;
        chk("to_edge_state", st[1], 5);
        chk("to_edge_commit", inst_update[1], 1);
        chk("to_edge_rf", rf_wen[1], 1);
        chk("to_edge_err", err[1], 0);
        rst1 = 1;

        // XLEN=32: ld is an illegal size
        rst2 = 0;
        tick();
        ifu_valid = 1;
        tick();
        ifu_valid = 0;
        tick();
        chk("x32_ld_state", st[2], 7);
        chk("x32_ld_err", err[2], 2);
        chk("x32_ld_req", lsu_req[2], 0);
        rst2 = 1;
        clear_inputs();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
